// File: rtl/stream_distributor_if.sv
// Stream bundle for the round-robin distributor: one upstream valid/ready port,
// NUM_ELEM downstream lanes sharing data/last, plus enable mask and status.
interface stream_distributor_if #(
  parameter int NUM_ELEM   = 4,
  parameter int DATA_WIDTH = 8
);
  localparam int SEL_W = $clog2(NUM_ELEM);

  logic [NUM_ELEM-1:0]   enable;
  logic [DATA_WIDTH-1:0] up_data;
  logic                  up_last;
  logic                  up_valid;
  logic                  up_ready;
  logic [DATA_WIDTH-1:0] dn_data;
  logic                  dn_last;
  logic [NUM_ELEM-1:0]   dn_valid;
  logic [NUM_ELEM-1:0]   dn_ready;
  logic [SEL_W-1:0]      sel;
  logic                  busy;

  modport slave (
    input  enable, up_data, up_last, up_valid, dn_ready,
    output up_ready, dn_data, dn_last, dn_valid, sel, busy
  );

  modport master (
    output enable, up_data, up_last, up_valid, dn_ready,
    input  up_ready, dn_data, dn_last, dn_valid, sel, busy
  );
endinterface

// File: rtl/stream_distributor.sv
// Round-robin packet distributor: picks an enabled output per packet and holds
// that choice until the last beat so packets never interleave across outputs.
module stream_distributor #(
  parameter int NUM_ELEM   = 4,
  parameter int DATA_WIDTH = 8
) (
  input  logic                 clk_i,
  input  logic                 rst_ni,
  stream_distributor_if.slave  bus
);
  localparam int SEL_W = $clog2(NUM_ELEM);

  localparam logic [0:0] ST_IDLE = 1'b0;
  localparam logic [0:0] ST_LOCK = 1'b1;

  logic [0:0]       state_r;
  logic [SEL_W-1:0] ptr_r;
  logic [SEL_W-1:0] dest_r;

  logic [SEL_W-1:0] rr_pick_s;
  logic [SEL_W:0]   cand_s;
  logic             found_s;
  logic             none_en_s;
  logic             none_eff_s;
  logic             lock_s;
  logic [SEL_W-1:0] cur_s;
  logic             ready_s;
  logic             hs_s;
  logic [NUM_ELEM-1:0] valid_s;

  function automatic logic [SEL_W-1:0] wrap_inc(input logic [SEL_W-1:0] v);
    if (v == SEL_W'(NUM_ELEM - 1)) begin
      return {SEL_W{1'b0}};
    end else begin
      return v + SEL_W'(1);
    end
  endfunction

  // First enabled output at or after ptr_r, scanning cyclically.
  always_comb begin
    rr_pick_s = {SEL_W{1'b0}};
    found_s   = 1'b0;
    cand_s    = {(SEL_W+1){1'b0}};
    for (int o = 0; o < NUM_ELEM; o++) begin
      cand_s = {1'b0, ptr_r} + (SEL_W+1)'(o);
      if (cand_s >= (SEL_W+1)'(NUM_ELEM)) begin
        cand_s = cand_s - (SEL_W+1)'(NUM_ELEM);
      end else begin
        cand_s = cand_s;
      end
      if (!found_s && bus.enable[cand_s[SEL_W-1:0]]) begin
        rr_pick_s = cand_s[SEL_W-1:0];
        found_s   = 1'b1;
      end else begin
        found_s   = found_s;
      end
    end
  end

  assign none_en_s  = (bus.enable == {NUM_ELEM{1'b0}});
  assign lock_s     = (state_r == ST_LOCK);
  // A locked packet must finish even if its enable bit drops.
  assign none_eff_s = lock_s ? 1'b0 : none_en_s;
  assign cur_s      = lock_s ? dest_r : rr_pick_s;
  assign ready_s    = rst_ni && !none_eff_s && bus.dn_ready[cur_s];
  assign hs_s       = bus.up_valid && ready_s;

  // One-hot lane valid towards the selected destination.
  always_comb begin
    valid_s = {NUM_ELEM{1'b0}};
    for (int i = 0; i < NUM_ELEM; i++) begin
      if (rst_ni && bus.up_valid && !none_eff_s && (cur_s == SEL_W'(i))) begin
        valid_s[i] = 1'b1;
      end else begin
        valid_s[i] = 1'b0;
      end
    end
  end

  assign bus.up_ready = ready_s;
  assign bus.dn_valid = valid_s;
  assign bus.dn_data  = bus.up_data;
  assign bus.dn_last  = bus.up_last;
  assign bus.sel      = cur_s;
  assign bus.busy     = lock_s;

  // Packet lock and round-robin pointer update.
  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      state_r <= ST_IDLE;
      ptr_r   <= {SEL_W{1'b0}};
      dest_r  <= {SEL_W{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (hs_s) begin
            if (bus.up_last) begin
              ptr_r <= wrap_inc(rr_pick_s);
            end else begin
              dest_r  <= rr_pick_s;
              state_r <= ST_LOCK;
            end
          end
        end
        ST_LOCK: begin
          if (hs_s && bus.up_last) begin
            state_r <= ST_IDLE;
            ptr_r   <= wrap_inc(dest_r);
          end
        end
        default: begin
          state_r <= ST_IDLE;
          ptr_r   <= {SEL_W{1'b0}};
          dest_r  <= {SEL_W{1'b0}};
        end
      endcase
    end
  end
endmodule
